pipeline_control: RTL and testbench
===================================

# pipeline_control

Central hazard controller for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB). It sits beside the datapath. It collects one stall request per stage and drives a stall (hold) and a flush (bubble) for the PC and each inter-stage register. It also forces a clean pipeline after reset and counts stall cycles for performance monitoring.

## Interface
- No parameters.

Ports:
- `clk` in 1 — Pipeline clock; all state updates on the rising edge.
- `rst_n` in 1 — Reset: one clock, synchronous, active-low.
- `IF_requireStall` in 1 — IF stage cannot complete this cycle.
- `ID_requireStall` in 1 — ID stage cannot complete (e.g. load-use hazard).
- `EX_requireStall` in 1 — EX stage cannot complete (e.g. multi-cycle ALU op).
- `MEM_requireStall` in 1 — MEM stage cannot complete (e.g. memory wait).
- `WB_requireStall` in 1 — WB stage cannot complete.
- `PC_stall` out 1 — Hold the PC.
- `IF_ID_stall`, `ID_EX_stall`, `EX_MEM_stall`, `MEM_WB_stall` out 1 each — Hold the named pipeline register.
- `IF_ID_flush`, `ID_EX_flush`, `EX_MEM_flush`, `MEM_WB_flush` out 1 each — Load a bubble (NOP) into the named register.
- `stallCycles` out 32 — Count of cycles in which `PC_stall` was 1.

## Operation
- Stage order: IF=0, ID=1, EX=2, MEM=3, WB=4.
- Find k = the highest-index stage with requireStall=1. The deepest request dominates; lower requests are subsumed.
- No request active: all stall and flush outputs are 0.
- Request at stage k:
  - `PC_stall`=1.
  - Every register feeding stage ≤ k stalls: IF_ID for k≥1, ID_EX for k≥2, EX_MEM for k≥3, MEM_WB for k≥4.
  - The register directly after stage k flushes: k=0→IF_ID, 1→ID_EX, 2→EX_MEM, 3→MEM_WB, 4→none.
  - All registers beyond that flush point run normally (stall=0, flush=0).
- Invariant: a register never sees stall=1 and flush=1 in the same cycle.
- Post-reset bubble:
  - Internal flag `initBubble` is set to 1 whenever `rst_n`=0 at a clock edge.
  - It clears at the first edge with `rst_n`=1.
  - While `initBubble`=1: `PC_stall`=1, all four flush outputs=1, all register stalls=0, regardless of the requests.
- `stallCycles`:
  - Cleared to 0 by reset.
  - Increments by 1 at each edge where `PC_stall`=1 and `initBubble`=0.
  - Saturates at 32'hFFFF_FFFF; no wrap-around.

## Timing
- All stall and flush outputs are combinational from the requireStall inputs and `initBubble`. They are valid in the same cycle as the request, with zero latency.
- Requests are level-sensitive; there is no handshake. Stage k must hold its request for as long as it needs the stall.
- Reset values:
  - `initBubble`=1 and `stallCycles`=0 after an edge with `rst_n`=0.
  - Outputs during reset: `PC_stall`=1, all flushes=1, all register stalls=0.
- Reset asserted mid-operation takes effect at the next edge; any pending stall is discarded.
- After `rst_n` rises:
  - Exactly one cycle of full flush with PC held (`initBubble` still 1).
  - Normal operation follows.
- `stallCycles` reflects stall cycles up to the previous edge (registered output).

## Structure
- Shared package `pipeline_pkg`:
  - Stage index enum (`STAGE_IF` .. `STAGE_WB`).
  - `NUM_STAGES`=5.
  - Counter width constant (32).
- Sub-module `stall_priority_encoder`: 5-bit request vector in → valid bit + 3-bit index of the deepest requesting stage.
- Top level holds:
  - Stall/flush decode from that index.
  - `initBubble` register.
  - Saturating counter.

## Test plan
- Reset held 2 cycles, then released with no requests: during reset and for one cycle after, `PC_stall`=1 and all flushes=1. Next cycle all outputs are 0. `stallCycles`=0.
- Single requests one at a time, each held 2 cycles:
  - IF → `PC_stall`, `IF_ID_flush`.
  - ID → `PC_stall`, `IF_ID_stall`, `ID_EX_flush`.
  - EX → `PC_stall`, IF_ID/ID_EX stall, `EX_MEM_flush`.
  - MEM → `PC_stall`, IF_ID/ID_EX/EX_MEM stall, `MEM_WB_flush`.
  - WB → `PC_stall` and all four register stalls, no flush.
- IF=1 and MEM=1 together: same as MEM alone; `IF_ID_flush`=0. All five requests together: same as WB alone.
- Counter: 10 cycles with EX=1 → `stallCycles`=10. Force the counter to 32'hFFFF_FFFE, then stall 3 cycles → counter holds 32'hFFFF_FFFF.
- Reset asserted during an EX stall: the next cycle shows the bubble pattern and `stallCycles`=0.
- Random requests for 1000 cycles: checker asserts that no register has stall=1 and flush=1 simultaneously, and that outputs match the priority rule.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the 5-stage pipeline hazard controller.
// Stage indices, stage count and stall-counter width.
package pipeline_pkg;

  localparam int NUM_STAGES = 5;
  localparam int CNT_W      = 32;

  typedef enum logic [2:0] {
    STAGE_IF  = 3'd0,
    STAGE_ID  = 3'd1,
    STAGE_EX  = 3'd2,
    STAGE_MEM = 3'd3,
    STAGE_WB  = 3'd4
  } stage_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value == {CNT_W{1'b1}}) ? value : value + CNT_W'(1);
  endfunction

endpackage

// File: rtl/stall_priority_encoder.sv
// Picks the deepest stage currently requesting a stall.
// Deeper stages dominate because their stall subsumes every earlier one.
module stall_priority_encoder
  import pipeline_pkg::*;
(
  input  logic [NUM_STAGES-1:0] req,
  output logic                  valid,
  output stage_e                idx
);

  always_comb begin
    valid = 1'b0;
    idx   = STAGE_IF;
    // Ascending scan: the last hit is the highest index.
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = stage_e'(i[2:0]);
      end
    end
  end

endmodule

// File: rtl/pipeline_control.sv
// Central stall/flush controller: decodes the deepest stall request,
// injects a full bubble after reset and counts PC-hold cycles.
module pipeline_control
  import pipeline_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IF_requireStall,
  input  logic             ID_requireStall,
  input  logic             EX_requireStall,
  input  logic             MEM_requireStall,
  input  logic             WB_requireStall,
  output logic             PC_stall,
  output logic             IF_ID_stall,
  output logic             ID_EX_stall,
  output logic             EX_MEM_stall,
  output logic             MEM_WB_stall,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             EX_MEM_flush,
  output logic             MEM_WB_flush,
  output logic [CNT_W-1:0] stallCycles
);

  logic [NUM_STAGES-1:0] req;
  logic                  req_valid;
  stage_e                req_idx;
  logic                  init_bubble;
  logic [CNT_W-1:0]      stall_cnt_q;
  logic [3:0]            reg_stall;
  logic [3:0]            reg_flush;
  logic                  pc_hold;

  assign req = {WB_requireStall, MEM_requireStall, EX_requireStall,
                ID_requireStall, IF_requireStall};

  stall_priority_encoder u_enc (
    .req   (req),
    .valid (req_valid),
    .idx   (req_idx)
  );

  // Register j sits between stage j and stage j+1: it holds when the
  // stalled stage is beyond it and takes the bubble when it is right after it.
  always_comb begin
    pc_hold   = 1'b0;
    reg_stall = 4'b0000;
    reg_flush = 4'b0000;
    if (init_bubble) begin
      pc_hold   = 1'b1;
      reg_flush = 4'b1111;
    end else if (req_valid) begin
      pc_hold = 1'b1;
      for (int j = 0; j < 4; j++) begin
        reg_stall[j] = (int'(req_idx) > j);
        reg_flush[j] = (int'(req_idx) == j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      init_bubble <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      init_bubble <= 1'b0;
      if (pc_hold && !init_bubble) begin
        stall_cnt_q <= sat_inc(stall_cnt_q);
      end
    end
  end

  assign PC_stall     = pc_hold;
  assign IF_ID_stall  = reg_stall[0];
  assign ID_EX_stall  = reg_stall[1];
  assign EX_MEM_stall = reg_stall[2];
  assign MEM_WB_stall = reg_stall[3];
  assign IF_ID_flush  = reg_flush[0];
  assign ID_EX_flush  = reg_flush[1];
  assign EX_MEM_flush = reg_flush[2];
  assign MEM_WB_flush = reg_flush[3];
  assign stallCycles  = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Scoreboard bench for pipeline_control: the driver pushes expected
// outputs from a reference model, a negedge monitor pops and compares.
module tb_pipeline_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  reqs = 5'b0;
  logic        PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_stall;
  logic        IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush;
  logic [31:0] stallCycles;

  typedef struct {
    logic [8:0]  outs;
    logic [31:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  logic        bubble_m;
  logic [31:0] cnt_m;

  always #5 clk = ~clk;

  pipeline_control dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .IF_requireStall  (reqs[0]),
    .ID_requireStall  (reqs[1]),
    .EX_requireStall  (reqs[2]),
    .MEM_requireStall (reqs[3]),
    .WB_requireStall  (reqs[4]),
    .PC_stall         (PC_stall),
    .IF_ID_stall      (IF_ID_stall),
    .ID_EX_stall      (ID_EX_stall),
    .EX_MEM_stall     (EX_MEM_stall),
    .MEM_WB_stall     (MEM_WB_stall),
    .IF_ID_flush      (IF_ID_flush),
    .ID_EX_flush      (ID_EX_flush),
    .EX_MEM_flush     (EX_MEM_flush),
    .MEM_WB_flush     (MEM_WB_flush),
    .stallCycles      (stallCycles)
  );

  // Packed as {pc, stall[MEM_WB..IF_ID], flush[MEM_WB..IF_ID]}.
  function automatic logic [8:0] expect_outs(input logic bubble, input logic [4:0] req);
    int k = -1;
    logic [3:0] st = 4'b0;
    logic [3:0] fl = 4'b0;
    if (bubble) return {1'b1, 4'b0000, 4'b1111};
    for (int i = 0; i < 5; i++) if (req[i]) k = i;
    if (k < 0) return 9'b0;
    for (int j = 0; j < 4; j++) begin
      st[j] = (k > j);
      fl[j] = (k == j);
    end
    return {1'b1, st, fl};
  endfunction

  task automatic step(input logic rst, input logic [4:0] req);
    exp_t e;
    logic [8:0] o;
    rst_n = rst;
    reqs  = req;
    o = expect_outs(bubble_m, req);
    e.outs = o;
    e.cnt  = cnt_m;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (!rst) begin
      bubble_m = 1'b1;
      cnt_m    = 32'd0;
    end else begin
      if (o[8] && !bubble_m && cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 32'd1;
      bubble_m = 1'b0;
    end
  endtask

  initial begin : monitor
    exp_t e;
    logic [8:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        act = {PC_stall, MEM_WB_stall, EX_MEM_stall, ID_EX_stall, IF_ID_stall,
               MEM_WB_flush, EX_MEM_flush, ID_EX_flush, IF_ID_flush};
        checks++;
        if (act !== e.outs) begin
          failures++;
          $display("FAIL outputs req=%b act=%b exp=%b t=%0t", reqs, act, e.outs, $time);
        end
        checks++;
        if (stallCycles !== e.cnt) begin
          failures++;
          $display("FAIL stallCycles act=%h exp=%h t=%0t", stallCycles, e.cnt, $time);
        end
        checks++;
        if ((act[7:4] & act[3:0]) != 4'b0) begin
          failures++;
          $display("FAIL stall_flush_overlap stall=%b flush=%b t=%0t", act[7:4], act[3:0], $time);
        end
      end
    end
  end

  initial begin : driver
    logic [4:0] r;
    rst_n = 1'b0;
    reqs  = 5'b0;
    @(posedge clk);
    #1;
    bubble_m = 1'b1;
    cnt_m    = 32'd0;

    // Reset held, release, bubble cycle, then idle.
    step(1'b0, 5'b0);
    step(1'b0, 5'b0);
    step(1'b1, 5'b0);
    step(1'b1, 5'b0);

    // Single requests, two cycles each, with an idle gap.
    for (int s = 0; s < 5; s++) begin
      r = 5'b1 << s;
      step(1'b1, r);
      step(1'b1, r);
      step(1'b1, 5'b0);
    end

    step(1'b1, 5'b01001);
    step(1'b1, 5'b11111);
    step(1'b1, 5'b0);

    // Ten EX stalls from a clean counter.
    step(1'b0, 5'b0);
    step(1'b1, 5'b0);
    for (int c = 0; c < 10; c++) step(1'b1, 5'b00100);
    step(1'b1, 5'b0);

    // Saturation near the top of the counter.
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    cnt_m = 32'hFFFF_FFFE;
    step(1'b1, 5'b0);
    for (int c = 0; c < 3; c++) step(1'b1, 5'b00100);
    step(1'b1, 5'b0);
    step(1'b1, 5'b0);

    // Reset during an EX stall.
    step(1'b1, 5'b00100);
    step(1'b0, 5'b00100);
    step(1'b1, 5'b00100);
    step(1'b1, 5'b00100);
    step(1'b1, 5'b0);

    // Random requests with occasional resets.
    for (int n = 0; n < 1000; n++) begin
      r = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) r = 5'b0;
      step(($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1, r);
    end

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain act=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
